// File: rtl/mole_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mole_datapath
//  Purpose  : Datapath for a whack-a-mole game.
//             - Pseudo-random source (16-bit Fibonacci LFSR).
//             - Phase countdown counter whose loads the game controller steers.
//             - Selection of the active hole.
//             - Key synchronisation, edge detection and hit qualification.
//             - Score, miss and game-over bookkeeping.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   system clock
//    resetn          in   1   asynchronous active-low reset
//    play            in   1   game-enable level
//    moleCounter_en  in   1   controller: counter active
//    mole_up         in   1   controller: mole visible
//    hit_signal      in   1   controller: one-cycle hit state
//    miss_signal     in   1   controller: one-cycle miss state
//    key             in   4   raw asynchronous push buttons, active-high
//    moleTimeCounter out  25  phase countdown to controller
//    hit             out  1   registered valid-whack pulse
//    hole            out  2   index of active mole
//    score           out  8   hits this game
//    misses          out  4   misses this game
//    game_over       out  1   sticky end-of-game flag
// ============================================================================
module mole_datapath #(
  parameter logic [24:0] DOWN_BASE  = 25'd12_500_000,
  parameter logic [24:0] UP_TIME    = 25'd25_000_000,
  parameter int          RAND_SHIFT = 16,
  parameter logic [3:0]  MAX_MISSES = 4'd5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        play,
  input  logic        moleCounter_en,
  input  logic        mole_up,
  input  logic        hit_signal,
  input  logic        miss_signal,
  input  logic [3:0]  key,
  output logic [24:0] moleTimeCounter,
  output logic        hit,
  output logic [1:0]  hole,
  output logic [7:0]  score,
  output logic [3:0]  misses,
  output logic        game_over
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [24:0] rand_ext;
  logic [24:0] dtime;
  logic        counter_active;
  logic        counter_zero;
  logic        phase_event;
  logic [3:0]  key_s1;
  logic [3:0]  key_s2;
  logic [3:0]  key_s3;
  logic [3:0]  key_rise;
  logic        play_d;
  logic        play_rise;
  logic [3:0]  misses_inc;

  // Taps 16,14,13,11 (1-based) -> bits 15,13,12,10, shifting toward the MSB.
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Random extension of the down period; the shift stays inside 25 bits so
  // anything pushed past bit 24 is simply truncated.
  assign rand_ext = {17'd0, lfsr[7:0]} << RAND_SHIFT;
  assign dtime    = DOWN_BASE + rand_ext;

  // A dropped play level forces the counter back to its idle load even if
  // the controller has not yet withdrawn its enable.
  assign counter_active = moleCounter_en & play;
  assign counter_zero   = (moleTimeCounter == 25'd0);
  assign phase_event    = hit_signal | miss_signal;

  assign play_rise  = play & ~play_d;
  assign misses_inc = misses + 4'd1;

  // --------------------------------------------------------------------------
  // LFSR: free-running every clock
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // --------------------------------------------------------------------------
  // Phase counter and hole selection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      moleTimeCounter <= DOWN_BASE;
      hole            <= 2'd0;
    end else begin
      if (phase_event) begin
        moleTimeCounter <= dtime;
      end else if (counter_active) begin
        if (counter_zero) begin
          if (mole_up) begin
            moleTimeCounter <= dtime;
          end else begin
            // Down phase over: open the up window and pick the hole.
            moleTimeCounter <= UP_TIME;
            hole            <= lfsr[1:0];
          end
        end else begin
          moleTimeCounter <= moleTimeCounter - 25'd1;
        end
      end else begin
        moleTimeCounter <= DOWN_BASE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Key synchroniser (two flops), edge detector and hit qualification.
  // Pin edge -> s1 -> s2 -> key_rise -> hit gives four clocks worst case.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_s1   <= 4'd0;
      key_s2   <= 4'd0;
      key_s3   <= 4'd0;
      key_rise <= 4'd0;
      hit      <= 1'b0;
    end else begin
      key_s1   <= key;
      key_s2   <= key_s1;
      key_s3   <= key_s2;
      key_rise <= key_s2 & ~key_s3;
      hit      <= mole_up & key_rise[hole] & ~game_over;
    end
  end

  // --------------------------------------------------------------------------
  // Score / miss bookkeeping. A play rising edge wins over any hit or miss
  // on the same cycle, and a hit wins over a simultaneous miss.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      play_d    <= 1'b0;
      score     <= 8'd0;
      misses    <= 4'd0;
      game_over <= 1'b0;
    end else begin
      play_d <= play;
      if (play_rise) begin
        score     <= 8'd0;
        misses    <= 4'd0;
        game_over <= 1'b0;
      end else if (hit_signal) begin
        if (score != 8'd255) begin
          score <= score + 8'd1;
        end
      end else if (miss_signal) begin
        if (misses != 4'd15) begin
          misses <= misses_inc;
          if (misses_inc == MAX_MISSES) begin
            game_over <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mole_datapath
//  Purpose  : Directed self-checking bench for mole_datapath, run with small
//             timing parameters so every phase fits in a few clocks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mole_datapath;

  logic        clk;
  logic        resetn;
  logic        play;
  logic        moleCounter_en;
  logic        mole_up;
  logic        hit_signal;
  logic        miss_signal;
  logic [3:0]  key;
  logic [24:0] moleTimeCounter;
  logic        hit;
  logic [1:0]  hole;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  mole_datapath #(
    .DOWN_BASE  (25'd10),
    .UP_TIME    (25'd20),
    .RAND_SHIFT (0),
    .MAX_MISSES (4'd3)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .play            (play),
    .moleCounter_en  (moleCounter_en),
    .mole_up         (mole_up),
    .hit_signal      (hit_signal),
    .miss_signal     (miss_signal),
    .key             (key),
    .moleTimeCounter (moleTimeCounter),
    .hit             (hit),
    .hole            (hole),
    .score           (score),
    .misses          (misses),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold one key for three clocks, watch eight clocks of hit output.
  task automatic press(input logic [1:0] h, output int hits, output int first);
    hits  = 0;
    first = 0;
    key   = 4'b0001 << h;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) key = 4'd0;
      if (hit) begin
        hits++;
        if (first == 0) first = k;
      end
    end
  endtask

  logic [1:0]  exp_hole;
  logic [31:0] exp_d;
  int          hits;
  int          first;

  initial begin
    resetn = 1'b0; play = 1'b0; moleCounter_en = 1'b0; mole_up = 1'b0;
    hit_signal = 1'b0; miss_signal = 1'b0; key = 4'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check_val("rst_cnt",   32'(moleTimeCounter), 32'd10);
    check_val("rst_hole",  32'(hole),            32'd0);
    check_val("rst_hit",   32'(hit),             32'd0);
    check_val("rst_score", 32'(score),           32'd0);
    check_val("rst_miss",  32'(misses),          32'd0);
    check_val("rst_go",    32'(game_over),       32'd0);

    // Down-phase countdown 10 -> 0, then load UP_TIME and latch hole
    resetn = 1'b1; play = 1'b1; moleCounter_en = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      tick();
      check_val("count_down", 32'(moleTimeCounter), 32'(i));
    end
    exp_hole = m_lfsr[1:0];
    tick();
    check_val("load_up",    32'(moleTimeCounter), 32'd20);
    check_val("hole_latch", 32'(hole),            32'(exp_hole));

    // Correct hole: exactly one pulse within 4 clocks; wrong hole: none
    mole_up = 1'b1;
    press(exp_hole, hits, first);
    check_val("hit_count", 32'(hits), 32'd1);
    check_val("hit_lat",   32'((first >= 1) && (first <= 4)), 32'd1);
    press(exp_hole + 2'd1, hits, first);
    check_val("wrong_hole", 32'(hits), 32'd0);

    // Simultaneous hit and miss: hit wins, counter loads dtime
    exp_d = 32'd10 + 32'(m_lfsr[7:0]);
    hit_signal = 1'b1; miss_signal = 1'b1;
    tick();
    check_val("both_score", 32'(score),           32'd1);
    check_val("both_miss",  32'(misses),          32'd0);
    check_val("both_cnt",   32'(moleTimeCounter), exp_d);
    miss_signal = 1'b0;

    // Score up to 7
    for (int i = 2; i <= 7; i++) begin
      tick();
      check_val("score_inc", 32'(score), 32'(i));
    end
    hit_signal = 1'b0;

    // Three misses end the game
    for (int i = 1; i <= 3; i++) begin
      exp_d = 32'd10 + 32'(m_lfsr[7:0]);
      miss_signal = 1'b1;
      tick();
      check_val("miss_inc", 32'(misses),          32'(i));
      check_val("go_flag",  32'(game_over),       32'(i == 3));
      check_val("miss_cnt", 32'(moleTimeCounter), exp_d);
    end
    miss_signal = 1'b0;
    press(exp_hole, hits, first);
    check_val("hit_after_go", 32'(hits), 32'd0);

    // Play dropped: counter to idle load, score/misses hold
    play = 1'b0;
    tick();
    check_val("idle_cnt",   32'(moleTimeCounter), 32'd10);
    check_val("hold_score", 32'(score),           32'd7);
    check_val("hold_miss",  32'(misses),          32'd3);
    check_val("hold_go",    32'(game_over),       32'd1);

    // Play rising edge clears everything, same-cycle hit is discarded
    play = 1'b1; hit_signal = 1'b1;
    tick();
    hit_signal = 1'b0;
    check_val("new_score", 32'(score),     32'd0);
    check_val("new_miss",  32'(misses),    32'd0);
    check_val("new_go",    32'(game_over), 32'd0);

    // Walk counter to 13: idle load, down to 0, load 20, down to 13
    moleCounter_en = 1'b0; mole_up = 1'b0;
    tick();
    check_val("en_off_cnt", 32'(moleTimeCounter), 32'd10);
    moleCounter_en = 1'b1;
    repeat (10) tick();
    check_val("cnt_zero", 32'(moleTimeCounter), 32'd0);
    exp_hole = m_lfsr[1:0];
    tick();
    check_val("load_up2",    32'(moleTimeCounter), 32'd20);
    check_val("hole_latch2", 32'(hole),            32'(exp_hole));
    repeat (7) tick();
    check_val("cnt_13", 32'(moleTimeCounter), 32'd13);

    // Asynchronous reset between edges
    #2 resetn = 1'b0;
    #1;
    check_val("arst_cnt",   32'(moleTimeCounter), 32'd10);
    check_val("arst_hole",  32'(hole),            32'd0);
    check_val("arst_hit",   32'(hit),             32'd0);
    check_val("arst_score", 32'(score),           32'd0);
    check_val("arst_go",    32'(game_over),       32'd0);
    check_val("arst_lfsr",  32'(dut.lfsr),        32'hACE1);

    // First edge after release is a normal count cycle
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_val("post_rst_cnt", 32'(moleTimeCounter), 32'd9);

    // Saturation
    hit_signal = 1'b1;
    repeat (256) tick();
    check_val("score_sat", 32'(score), 32'd255);
    hit_signal = 1'b0; miss_signal = 1'b1;
    repeat (16) tick();
    check_val("miss_sat", 32'(misses),    32'd15);
    check_val("sat_go",   32'(game_over), 32'd1);
    miss_signal = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
